// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer reader.
// Geometry is fixed at 640x480 scanned from a 160x120 12-bit framebuffer.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int FB_DEPTH    = 19200;
  localparam int ADDR_W      = 15;
  localparam int COLOR_W     = 4;
  localparam int RGB_W       = 3 * COLOR_W;

  typedef logic [RGB_W-1:0] rgb12_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  // y*160 + x without a multiplier: 160 = 128 + 32
  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [9:0] h,
    input logic [9:0] v
  );
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    x = ADDR_W'(h >> SCALE_SHIFT);
    y = ADDR_W'(v >> SCALE_SHIFT);
    return (y << 7) + (y << 5) + x;
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM, 19200 x 12.
// One write port, one registered read port (read-before-write).
import vga_pkg::*;

module vga_fb_ram (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rgb12_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output rgb12_t            rdata
);

  rgb12_t mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_reader.sv
// Framebuffer-backed VGA pixel source with write port and clear engine.
// Syncs travel through the same two tick stages as the colour path.
import vga_pkg::*;

module vga_fb_reader (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               pix_en,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [RGB_W-1:0]   wr_data,
  input  logic               clr_req,
  input  logic [RGB_W-1:0]   clr_color,
  output logic               clr_busy,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);

  clr_state_t        state_q;
  clr_state_t        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  rgb12_t            col_q;
  rgb12_t            col_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  rgb12_t            ram_wdata;
  rgb12_t            ram_q;
  logic              wr_fire;

  logic              active_s0;
  logic [ADDR_W-1:0] addr_s0;
  logic              hs_s0;
  logic              vs_s0;
  rgb12_t            rgb_q;
  logic              hs_q;
  logic              vs_q;

  assign wr_ready = (state_q == IDLE) & ~clr_req;
  assign wr_fire  = wr_valid & wr_ready;
  assign clr_busy = (state_q == CLEAR);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          col_d   = clr_color;
        end else if (wr_fire && (wr_addr < DEPTH)) begin
          ram_we = 1'b1;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = col_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  vga_fb_ram u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr_s0),
    .rdata (ram_q)
  );

  // Ticks are >=2 clocks apart, so ram_q is settled by the next tick
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      active_s0 <= 1'b0;
      addr_s0   <= '0;
      hs_s0     <= 1'b1;
      vs_s0     <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else if (pix_en) begin
      active_s0 <= (h_cnt < 10'(H_ACTIVE))
                 & (v_cnt < 10'(V_ACTIVE));
      addr_s0   <= fb_addr(h_cnt, v_cnt);
      hs_s0     <= hs_in;
      vs_s0     <= vs_in;
      rgb_q     <= active_s0 ? ram_q : '0;
      hs_q      <= hs_s0;
      vs_q      <= vs_s0;
    end
  end

  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader with a pixel-level reference model.
// Model maps every tick to a framebuffer word and predicts outputs one tick on.
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hs_in;
  logic        vs_in;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;

  int n_pass = 0;
  int n_tot  = 0;

  logic [11:0] fb_model [19200];
  bit          fb_known [19200];

  logic [11:0] pv_rgb;
  logic        pv_hs;
  logic        pv_vs;
  bit          pv_known;

  always #10 clk = ~clk;

  vga_fb_reader dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .VGA_R     (vga_r),
    .VGA_G     (vga_g),
    .VGA_B     (vga_b),
    .VGA_HS    (vga_hs),
    .VGA_VS    (vga_vs)
  );

  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: each tick's pixel appears on the pins at the following tick
  always @(posedge clk) begin
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
    bit          e_known;
    bit          act;
    int          a;
    if (!rst_n) begin
      pv_rgb   = '0;
      pv_hs    = 1'b1;
      pv_vs    = 1'b1;
      pv_known = 1;
    end else if (pix_en) begin
      e_rgb   = pv_rgb;
      e_hs    = pv_hs;
      e_vs    = pv_vs;
      e_known = pv_known;
      act = (int'(h_cnt) < 640) && (int'(v_cnt) < 480);
      a   = (int'(v_cnt) / 4) * 160 + int'(h_cnt) / 4;
      pv_rgb   = act ? fb_model[a] : 12'h000;
      pv_known = !act || fb_known[a];
      pv_hs    = hs_in;
      pv_vs    = vs_in;
      #1;
      if (e_known) chk("model_rgb", rgb(), e_rgb);
      chk("model_hs", vga_hs, e_hs);
      chk("model_vs", vga_vs, e_vs);
    end
  end

  task automatic tick(input int h, input int v,
                      input logic hs, input logic vs);
    @(negedge clk);
    pix_en = 1'b1;
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    hs_in  = hs;
    vs_in  = vs;
    @(negedge clk);
    pix_en = 1'b0;
    #1;
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = 15'(a);
    wr_data  = d;
    #1 chk("wr_ready", wr_ready, 1'b1);
    @(posedge clk);
    if (a < 19200) begin
      fb_model[a] = d;
      fb_known[a] = 1;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic run_clear(input logic [11:0] c, output int cyc,
                           output int rdy_hi);
    @(negedge clk);
    clr_req   = 1'b1;
    clr_color = c;
    wr_valid  = 1'b1;
    wr_addr   = 15'd5;
    wr_data   = 12'hABC;
    #1 chk("wr_ready_vs_clr", wr_ready, 1'b0);
    @(negedge clk);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    cyc    = 0;
    rdy_hi = 0;
    #1;
    while (clr_busy && cyc < 20000) begin
      cyc++;
      if (wr_ready) rdy_hi++;
      @(negedge clk);
      #1;
    end
    for (int i = 0; i < 19200; i++) begin
      fb_model[i] = c;
      fb_known[i] = 1;
    end
  endtask

  initial begin
    int cyc;
    int rdy_hi;
    int lows;
    int first_low;
    rst_n     = 1'b0;
    pix_en    = 1'b0;
    h_cnt     = '0;
    v_cnt     = '0;
    hs_in     = 1'b1;
    vs_in     = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_req   = 1'b0;
    clr_color = '0;
    for (int i = 0; i < 19200; i++) fb_known[i] = 0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pix_en    = 1'($urandom);
      h_cnt     = 10'($urandom);
      v_cnt     = 10'($urandom);
      hs_in     = 1'($urandom);
      vs_in     = 1'($urandom);
      wr_valid  = 1'($urandom);
      wr_addr   = 15'($urandom);
      wr_data   = 12'($urandom);
      clr_req   = 1'($urandom);
      clr_color = 12'($urandom);
      #1;
      chk("rst_rgb", rgb(), 12'h000);
      chk("rst_hs", vga_hs, 1'b1);
      chk("rst_vs", vga_vs, 1'b1);
      chk("rst_busy", clr_busy, 1'b0);
    end
    @(negedge clk);
    pix_en   = 1'b0;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    hs_in    = 1'b1;
    vs_in    = 1'b1;
    rst_n    = 1'b1;
    #1 chk("ready_after_rst", wr_ready, 1'b1);

    wr(0, 12'hF00);
    wr(1, 12'h00F);
    for (int line = 0; line < 2; line++) begin
      for (int h = 0; h <= 8; h++) begin
        tick(h, line * 3, 1'b1, 1'b1);
        if (h > 0)
          chk("row_lit", rgb(), (h - 1) < 4 ? 12'hF00 : 12'h00F);
      end
    end

    wr(19199, 12'h0F0);
    for (int v = 476; v <= 479; v++) begin
      for (int h = 636; h <= 641; h++) begin
        tick(h, v, 1'b1, 1'b1);
        if (h > 636)
          chk("corner_lit", rgb(), (h - 1) < 640 ? 12'h0F0 : 12'h000);
      end
    end
    tick(0, 480, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1);
    chk("v480_lit", rgb(), 12'h000);

    wr(19200, 12'h123);
    tick(636, 479, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1);
    chk("oob_corner", rgb(), 12'h0F0);
    tick(900, 600, 1'b1, 1'b1);
    chk("oob_addr0", rgb(), 12'hF00);
    tick(0, 0, 1'b1, 1'b1);
    chk("oob_cnt_lit", rgb(), 12'h000);

    lows      = 0;
    first_low = -1;
    for (int h = 640; h <= 800; h++) begin
      if (h < 800)
        tick(h, 10, !(h >= 656 && h <= 751), 1'b1);
      else
        tick(0, 11, 1'b1, 1'b1);
      if (h > 640 && !vga_hs) begin
        lows++;
        if (first_low < 0) first_low = h;
      end
    end
    chk("hs_low_ticks", lows, 96);
    chk("hs_first_low", first_low, 657);

    run_clear(12'h0F0, cyc, rdy_hi);
    chk("clr_cycles", cyc, 19200);
    chk("clr_ready_low", rdy_hi, 0);
    tick(0, 0, 1'b1, 1'b1);
    tick(0, 240, 1'b1, 1'b1);
    chk("clr_a0", rgb(), 12'h0F0);
    tick(639, 479, 1'b1, 1'b1);
    chk("clr_a9600", rgb(), 12'h0F0);
    tick(20, 0, 1'b1, 1'b1);
    chk("clr_a19199", rgb(), 12'h0F0);
    tick(0, 0, 1'b1, 1'b1);
    chk("clr_a5", rgb(), 12'h0F0);

    @(negedge clk);
    clr_req   = 1'b1;
    clr_color = 12'h00F;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (4999) @(negedge clk);
    chk("mid_busy", clr_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", clr_busy, 1'b0);
    chk("mid_rst_ready", wr_ready, 1'b1);
    for (int i = 0; i < 19200; i++) fb_known[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_busy", clr_busy, 1'b0);

    run_clear(12'hF0F, cyc, rdy_hi);
    chk("clr2_cycles", cyc, 19200);
    chk("clr2_ready_low", rdy_hi, 0);
    tick(0, 0, 1'b1, 1'b1);
    tick(639, 479, 1'b1, 1'b1);
    chk("clr2_a0", rgb(), 12'hF0F);
    tick(0, 0, 1'b0, 1'b0);
    chk("clr2_a19199", rgb(), 12'hF0F);
    tick(0, 0, 1'b1, 1'b1);
    chk("vs_low_lit", vga_vs, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
